mc_video_out: RTL
=================

Name: mc_video_out

Overview:
- Parametrised video output stage between the Multicomp video generator and the MiSTer VGA_* outputs.
- Registers all video signals on the pixel enable.
- Expands N-bit colour to 8-bit by bit replication and forces black during blanking.
- Auto-detects and normalises HS/VS polarity to active-high, aligns VS changes to the HS leading edge, and generates DE.

Parameters:
- COLOR_W, 2, input bits per colour channel (1..8).
- OUT_W, 8, output bits per colour channel (>= COLOR_W).
- HCNT_W, 12, width of the per-line pixel counters used for HS polarity detection (saturating).
- VCNT_W, 11, width of the per-frame line counters used for VS polarity detection (saturating).

Ports:
- clk  in  1  pixel/system clock (CLK_VIDEO domain).
- n_reset  in  1  asynchronous, active-low reset.
- ce_pix  in  1  pixel clock enable; all state advances only when high.
- r_in, g_in, b_in  in  COLOR_W each  raw colour.
- hs_in, vs_in  in  1  raw sync, either polarity.
- hblank_in, vblank_in  in  1  active-high blanking.
- vga_r, vga_g, vga_b  out  OUT_W each  expanded colour.
- vga_hs, vga_vs  out  1  normalised sync, active-high.
- vga_de  out  1  ~(hblank|vblank), registered.
- hs_pol, vs_pol  out  1  detected input polarity (1 = input active-high).

Behaviour:
- Reset (async assert, sync deassert handled by the caller): all outputs 0; hs_pol = vs_pol = 0 (active-low input assumed); all counters 0; previous-sample registers 0.
- ce_pix low: every register holds, outputs hold.
- Latency is 1 ce_pix cycle for colour, DE and HS: values sampled on ce_pix cycle n appear after the edge of cycle n.
- Colour expansion: output = input repeated MSB-first and truncated to OUT_W.
  - 2'b10 -> 8'hAA.
  - 3'b101 -> 8'b10110110.
  - 1'b1 -> 8'hFF.
- Blanking: when hblank_in|vblank_in is sampled high, the colour outputs are 0 and vga_de is 0.
- HS polarity detection (mc_sync_polarity, horizontal instance):
  - Counts ce_pix cycles with hs_in high (cnt_hi) and low (cnt_lo), each saturating at 2^HCNT_W-1.
  - On each rising edge of hs_in (a "period end"), compare the counters:
    - cnt_hi < cnt_lo -> pol = 1.
    - cnt_hi > cnt_lo -> pol = 0.
    - equal -> pol unchanged.
  - Both counters then restart, with the current sample counted.
  - No decision is made before the first complete period after reset.
- VS polarity detection: identical, but the counters advance only on the normalised HS leading edge (lines). The period end is the rising edge of vs_in, and the counters are VCNT_W wide.
- Normalisation: hs_n = hs_in ^ ~hs_pol; vs_n = vs_in ^ ~vs_pol. A polarity change takes effect from the next ce_pix cycle.
- VS alignment: vga_vs updates only on a ce_pix cycle where hs_n rises (0->1). Otherwise it holds. A VS edge coincident with an HS rising edge is taken in that same cycle.
- Simultaneous period end and saturation: the decision uses the saturated values. Two saturated counters are treated as equal, so pol is unchanged.
- Reset mid-frame: everything returns to reset values immediately. Detection restarts, and the first decision comes at the second rising edge of the sync input.

Optional Feature:
- Macro: MC_VIDEO_SCANLINE_EN.
- When defined:
  - Adds input port sl_en (1 bit).
  - A line-parity flag toggles on each hs_n rising edge and clears on each vs_n rising edge.
  - When sl_en=1 and parity=1, each expanded colour is shifted right by 1 (50% dim), applied in the same output register, so latency is unchanged.
- When undefined: no sl_en port, no parity flag, colour passes undimmed.

Decomposition:
- Package mc_video_pkg:
  - Default constants for OUT_W, HCNT_W and VCNT_W.
  - Function expand_color(value, in_w, out_w) implementing the replication rule.
  - Typedef for the rgb triple at OUT_W.
- Sub-module mc_sync_polarity:
  - Parameter CNT_W; ports clk, n_reset, ce (count enable), sync_in, sync_out, pol.
  - Instantiated twice: the horizontal instance with ce = ce_pix, the vertical instance with ce = ce_pix & hs_n rising.

Test Plan:
- COLOR_W=2, r/g/b = 2'b10/2'b01/2'b11 with blanking low -> vga_r/g/b = 8'hAA/8'h55/8'hFF one ce_pix later, and vga_de=1.
- hblank_in=1 with colour 2'b11 -> vga_r/g/b = 0 and vga_de=0 on the next ce_pix.
- Active-low HS input (96 cycles low of 800 per line), 3 lines -> hs_pol stays 0 and vga_hs is high for exactly 96 ce_pix per line. Switching to an active-high input (96 high / 704 low) -> hs_pol=1 after the second rising edge, and vga_hs is again a 96-cycle high pulse.
- vs_in toggles mid-line (200 ce_pix after an HS rising edge) -> vga_vs changes only at the next hs_n rising edge, never earlier.
- ce_pix held low for 50 clocks with changing inputs -> all outputs and counters unchanged. n_reset pulsed low mid-line -> all outputs 0 asynchronously, and hs_pol returns to 0.
- With MC_VIDEO_SCANLINE_EN and sl_en=1, full-white input -> even lines 8'hFF, odd lines 8'h7F. Parity clears at the vs_n rising edge.

Source files
------------

// File: rtl/mc_video_pkg.sv
// Shared constants, rgb typedef and colour-replication helper for the Multicomp video output stage.
package mc_video_pkg;

    localparam int OUT_W_DEF  = 8;
    localparam int HCNT_W_DEF = 12;
    localparam int VCNT_W_DEF = 11;
    localparam int EXP_MAX    = 16;

    typedef struct packed {
        logic [OUT_W_DEF-1:0] r;
        logic [OUT_W_DEF-1:0] g;
        logic [OUT_W_DEF-1:0] b;
    } rgb_t;

    // Repeats the in_w-bit value MSB-first until out_w bits are filled; result sits in [out_w-1:0].
    function automatic logic [EXP_MAX-1:0] expand_color(input logic [7:0] value,
                                                        input int in_w,
                                                        input int out_w);
        logic [EXP_MAX-1:0] result;
        logic [2:0]         idx;
        result = '0;
        for (int i = 0; i < EXP_MAX; i++) begin
            if (i < out_w) begin
                idx    = 3'(in_w - 1 - (i % in_w));
                result = {result[EXP_MAX-2:0], value[idx]};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mc_sync_polarity.sv
// Sync polarity detector: compares high/low durations between rising edges of sync_in
// and presents the sync normalised to active-high.
module mc_sync_polarity
    import mc_video_pkg::*;
#(
    parameter int CNT_W = HCNT_W_DEF
) (
    input  logic clk,
    input  logic n_reset,
    input  logic ce,
    input  logic sync_in,
    output logic sync_out,
    output logic pol
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             prev;
    logic             armed;
    logic [CNT_W-1:0] cnt_hi;
    logic [CNT_W-1:0] cnt_lo;
    logic             period_end;

    assign period_end = sync_in & ~prev;
    assign sync_out   = sync_in ^ ~pol;

    // The first rising edge after reset only arms the detector, since the period before it is partial.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            prev   <= 1'b0;
            armed  <= 1'b0;
            cnt_hi <= '0;
            cnt_lo <= '0;
            pol    <= 1'b0;
        end else if (ce) begin
            prev <= sync_in;
            if (period_end) begin
                armed <= 1'b1;
                if (armed) begin
                    if (cnt_hi < cnt_lo) begin
                        pol <= 1'b1;
                    end else if (cnt_hi > cnt_lo) begin
                        pol <= 1'b0;
                    end
                end
                cnt_hi <= CNT_W'(1);
                cnt_lo <= '0;
            end else if (sync_in) begin
                if (cnt_hi != CNT_MAX) begin
                    cnt_hi <= cnt_hi + CNT_W'(1);
                end
            end else begin
                if (cnt_lo != CNT_MAX) begin
                    cnt_lo <= cnt_lo + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mc_video_out.sv
// Video output stage: colour expansion, blanking, sync polarity normalisation, VS-to-HS alignment, DE.
// Optional scanline dimming is enabled by defining MC_VIDEO_SCANLINE_EN.
module mc_video_out
    import mc_video_pkg::*;
#(
    parameter int COLOR_W = 2,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int HCNT_W  = HCNT_W_DEF,
    parameter int VCNT_W  = VCNT_W_DEF
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               ce_pix,
`ifdef MC_VIDEO_SCANLINE_EN
    input  logic               sl_en,
`endif
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               hblank_in,
    input  logic               vblank_in,
    output logic [OUT_W-1:0]   vga_r,
    output logic [OUT_W-1:0]   vga_g,
    output logic [OUT_W-1:0]   vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de,
    output logic               hs_pol,
    output logic               vs_pol
);

    logic             hs_n;
    logic             vs_n;
    logic             hs_rise;
    logic             line_ce;
    logic             blank;
    logic [OUT_W-1:0] r_exp, g_exp, b_exp;
    logic [OUT_W-1:0] r_nxt, g_nxt, b_nxt;

    // vga_hs is the registered hs_n, so it doubles as the previous sample for edge detection.
    assign hs_rise = hs_n & ~vga_hs;
    assign line_ce = ce_pix & hs_rise;
    assign blank   = hblank_in | vblank_in;

    assign r_exp = OUT_W'(expand_color(8'(r_in), COLOR_W, OUT_W));
    assign g_exp = OUT_W'(expand_color(8'(g_in), COLOR_W, OUT_W));
    assign b_exp = OUT_W'(expand_color(8'(b_in), COLOR_W, OUT_W));

    mc_sync_polarity #(.CNT_W(HCNT_W)) u_hs_pol (
        .clk      (clk),
        .n_reset  (n_reset),
        .ce       (ce_pix),
        .sync_in  (hs_in),
        .sync_out (hs_n),
        .pol      (hs_pol)
    );

    mc_sync_polarity #(.CNT_W(VCNT_W)) u_vs_pol (
        .clk      (clk),
        .n_reset  (n_reset),
        .ce       (line_ce),
        .sync_in  (vs_in),
        .sync_out (vs_n),
        .pol      (vs_pol)
    );

`ifdef MC_VIDEO_SCANLINE_EN
    logic parity;
    logic vs_n_prev;

    always_comb begin
        r_nxt = r_exp;
        g_nxt = g_exp;
        b_nxt = b_exp;
        if (sl_en && parity) begin
            r_nxt = r_exp >> 1;
            g_nxt = g_exp >> 1;
            b_nxt = b_exp >> 1;
        end
    end

    // Frame start wins over the line toggle so the first line of each frame is undimmed.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            parity    <= 1'b0;
            vs_n_prev <= 1'b0;
        end else if (ce_pix) begin
            vs_n_prev <= vs_n;
            if (vs_n & ~vs_n_prev) begin
                parity <= 1'b0;
            end else if (hs_rise) begin
                parity <= ~parity;
            end
        end
    end
`else
    always_comb begin
        r_nxt = r_exp;
        g_nxt = g_exp;
        b_nxt = b_exp;
    end
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= 1'b0;
            vga_vs <= 1'b0;
            vga_de <= 1'b0;
        end else if (ce_pix) begin
            vga_r  <= blank ? '0 : r_nxt;
            vga_g  <= blank ? '0 : g_nxt;
            vga_b  <= blank ? '0 : b_nxt;
            vga_de <= ~blank;
            vga_hs <= hs_n;
            if (hs_rise) begin
                vga_vs <= vs_n;
            end
        end
    end

endmodule
